mdio_phy_responder: RTL
=======================

Name: mdio_phy_responder

Overview:
- PHY-side MDIO management responder (IEEE 802.3 clause 22); the responding end of the MAC's Mdc/Mdio station-management master.
- Oversamples Mdc/Mdio on one system clock, decodes read/write frames addressed to its PHY address, and bridges them onto a simple register-file port.
- Instantiated in the PHY model next to the MAC; the bench supplies the tri-state buffer.

Parameters:
- PHY_ADDR, 5'd1, PHY address this block answers to.
- PRE_MIN, 32, consecutive preamble 1s required before a start of frame is accepted.
- SYNC_STAGES, 2, synchronizer depth applied to both Mdc and Mdio_in.

Ports:
- Clk  in  1  system clock; frequency must be at least 8x Mdc.
- Reset  in  1  synchronous reset, active-high.
- Mdc  in  1  management clock from the MAC (asynchronous to Clk).
- Mdio_in  in  1  Mdio pad input.
- Mdio_out  out  1  Mdio pad output value.
- Mdio_oe  out  1  Mdio pad output enable; 0 = high-Z.
- Reg_addr  out  5  register address of the current or last frame.
- Reg_wr_en  out  1  one-Clk write strobe.
- Reg_wdata  out  16  write data; valid while Reg_wr_en=1.
- Reg_rdata  in  16  read data for Reg_addr; combinational from the register file.
- Frame_err  out  1  one-Clk pulse on a malformed frame.

Behaviour:
- Reset values: Mdio_out=1, Mdio_oe=0, Reg_addr=0, Reg_wr_en=0, Reg_wdata=0, Frame_err=0. All state and counters clear and the FSM goes to PRE. A reset mid-frame abandons the frame immediately with no write strobe.
- Sampling: Mdc and Mdio_in pass through SYNC_STAGES flops, in matched pipelines.
  - rise = sync_mdc & ~mdc_d1. All bit processing happens only on Clk cycles where rise=1.
  - The Mdio sample used on a rise is the synchronized value from the same cycle.
- Preamble counter: 6-bit, saturating at PRE_MIN.
  - A sampled 1 increments it.
  - A sampled 0 with count < PRE_MIN clears it.
  - Cleared on every return to PRE.
- FSM states: PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA. The bit counter loads on every state entry.
  - PRE: a sampled 0 with count = PRE_MIN goes to ST (this 0 is ST bit0).
  - ST: expect 1. Anything else raises Frame_err and returns to PRE.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 raises Frame_err and returns to PRE.
  - PHYAD: 5 bits, MSB first. On mismatch with PHY_ADDR, go to PRE silently (no Frame_err, no drive).
  - REGAD: 5 bits, MSB first, shifted into Reg_addr. Reg_addr updates only here and holds otherwise.
  - TA, write: expect 1 then 0. Otherwise raise Frame_err and return to PRE.
  - TA, read, bit 1: Mdio_oe stays 0.
  - TA, read, bit 2: on the rise ending TA bit 1, capture Reg_rdata into a 16-bit shift register and set Mdio_oe=1, Mdio_out=0. Both take effect 1 Clk after that rise.
  - WDATA: 16 bits, MSB first. On the 16th sampled bit, Reg_wdata takes the full word and Reg_wr_en=1 for exactly 1 Clk (the cycle after the rise). Then go to PRE.
  - RDATA: on each rise, Mdio_out takes the next bit, starting with bit 15 on the rise ending TA bit 2. On the rise after bit 0 has been driven, Mdio_oe=0, Mdio_out=1, and the FSM goes to PRE.
- Back-to-back frames: a new preamble may start on the rise immediately after the previous frame's last bit.
- Frame_err and Reg_wr_en never assert in the same cycle.
- Mdc falling edges are ignored. Mdc glitches narrower than 1 Clk are not supported.

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: after one complete valid frame addressed to PHY_ADDR, a 0 seen in PRE is accepted as ST bit0 regardless of the preamble count (clause 22 preamble suppression). The enable flag clears on Reset and on any Frame_err.
- Undefined: PRE_MIN ones are always required, and no enable flag exists.

Test Plan:
- Write: 32 ones, 01, 01, PHYAD=00001, REGAD=00100, TA=10, data 16'hA5C3 -> one Reg_wr_en pulse with Reg_addr=4 and Reg_wdata=16'hA5C3. Mdio_oe stays 0 throughout.
- Read: REGAD=00010, Reg_rdata=16'h1234 -> Mdio_oe rises after TA bit 1. Bits driven are 0, then 0001001000110100 MSB first. Mdio_oe drops after the final bit.
- Wrong address: PHYAD=00011 read -> Mdio_oe never asserts, no Frame_err, and the next valid frame is accepted.
- Malformed: OP=11 -> Frame_err pulse. Write TA=11 -> Frame_err and no Reg_wr_en. Only 31 preamble ones before ST -> frame ignored.
- Reset mid-frame: assert Reset during WDATA bit 8 -> outputs at reset values and no write; a subsequent full frame works.
- Preamble suppression (macro defined): valid write, then an immediate second write with no preamble -> second Reg_wr_en occurs. Without the macro -> second frame ignored.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// rtl/mdio_phy_responder.sv - Clause 22 MDIO PHY-side responder bridging frames onto a register port
// Optional MDIO_PREAMBLE_SUPPRESS_EN: after a valid frame, a 0 in PRE starts a frame without preamble.
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR    = 5'd1,
    parameter int         PRE_MIN     = 32,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mdc,
    input  logic        Mdio_in,
    output logic        Mdio_out,
    output logic        Mdio_oe,
    output logic [4:0]  Reg_addr,
    output logic        Reg_wr_en,
    output logic [15:0] Reg_wdata,
    input  logic [15:0] Reg_rdata,
    output logic        Frame_err
);

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
    } state_t;

    localparam logic [5:0] PRE_MAX = 6'(PRE_MIN);

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic                   mdc_d1;
    logic                   rise;
    logic                   bit_in;
    logic                   pre_ok;

    state_t      state;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic        is_read;
    logic [15:0] shreg;
    logic [15:0] rd_shift;

    // Both inputs share the same pipeline depth so a sample lines up with its Mdc edge (SYNC_STAGES >= 2).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
            mdc_d1    <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], Mdc};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], Mdio_in};
            mdc_d1    <= mdc_sync[SYNC_STAGES-1];
        end
    end

    assign rise   = mdc_sync[SYNC_STAGES-1] & ~mdc_d1;
    assign bit_in = mdio_sync[SYNC_STAGES-1];

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic supp_en;
    logic frame_done;

    assign frame_done = rise && (bit_cnt == 5'd1) && (state == S_WDATA || state == S_RDATA);
    assign pre_ok     = (pre_cnt == PRE_MAX) || supp_en;

    always_ff @(posedge Clk) begin
        if (Reset || Frame_err) supp_en <= 1'b0;
        else if (frame_done)    supp_en <= 1'b1;
    end
`else
    assign pre_ok = (pre_cnt == PRE_MAX);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_PRE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            is_read   <= 1'b0;
            shreg     <= '0;
            rd_shift  <= '0;
            Mdio_out  <= 1'b1;
            Mdio_oe   <= 1'b0;
            Reg_addr  <= '0;
            Reg_wr_en <= 1'b0;
            Reg_wdata <= '0;
            Frame_err <= 1'b0;
        end else begin
            Reg_wr_en <= 1'b0;
            Frame_err <= 1'b0;
            if (rise) begin
                // Holding the count at zero outside PRE means every return to PRE starts fresh.
                if (state != S_PRE) pre_cnt <= '0;
                bit_cnt <= bit_cnt - 5'd1;
                case (state)
                    S_PRE: begin
                        if (bit_in) begin
                            if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 6'd1;
                        end else if (pre_ok) begin
                            state   <= S_ST;
                            bit_cnt <= 5'd1;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    S_ST: begin
                        if (bit_in) begin
                            state   <= S_OP;
                            bit_cnt <= 5'd2;
                        end else begin
                            Frame_err <= 1'b1;
                            state     <= S_PRE;
                        end
                    end
                    S_OP: begin
                        shreg <= {shreg[14:0], bit_in};
                        if (bit_cnt == 5'd1) begin
                            if ({shreg[0], bit_in} == 2'b10 || {shreg[0], bit_in} == 2'b01) begin
                                is_read <= shreg[0];
                                state   <= S_PHYAD;
                                bit_cnt <= 5'd5;
                            end else begin
                                Frame_err <= 1'b1;
                                state     <= S_PRE;
                            end
                        end
                    end
                    S_PHYAD: begin
                        shreg <= {shreg[14:0], bit_in};
                        if (bit_cnt == 5'd1) begin
                            if ({shreg[3:0], bit_in} == PHY_ADDR) begin
                                state   <= S_REGAD;
                                bit_cnt <= 5'd5;
                            end else begin
                                state <= S_PRE;
                            end
                        end
                    end
                    S_REGAD: begin
                        Reg_addr <= {Reg_addr[3:0], bit_in};
                        if (bit_cnt == 5'd1) begin
                            state   <= S_TA;
                            bit_cnt <= 5'd2;
                        end
                    end
                    S_TA: begin
                        if (is_read) begin
                            // Turnaround: take the bus with a 0 after TA bit 1, present bit 15 after TA bit 2.
                            if (bit_cnt == 5'd2) begin
                                rd_shift <= Reg_rdata;
                                Mdio_oe  <= 1'b1;
                                Mdio_out <= 1'b0;
                            end else begin
                                Mdio_out <= rd_shift[15];
                                rd_shift <= {rd_shift[14:0], 1'b0};
                                state    <= S_RDATA;
                                bit_cnt  <= 5'd16;
                            end
                        end else if (bit_in != (bit_cnt == 5'd2)) begin
                            Frame_err <= 1'b1;
                            state     <= S_PRE;
                        end else if (bit_cnt == 5'd1) begin
                            state   <= S_WDATA;
                            bit_cnt <= 5'd16;
                        end
                    end
                    S_WDATA: begin
                        shreg <= {shreg[14:0], bit_in};
                        if (bit_cnt == 5'd1) begin
                            Reg_wdata <= {shreg[14:0], bit_in};
                            Reg_wr_en <= 1'b1;
                            state     <= S_PRE;
                        end
                    end
                    S_RDATA: begin
                        if (bit_cnt == 5'd1) begin
                            Mdio_oe  <= 1'b0;
                            Mdio_out <= 1'b1;
                            state    <= S_PRE;
                        end else begin
                            Mdio_out <= rd_shift[15];
                            rd_shift <= {rd_shift[14:0], 1'b0};
                        end
                    end
                    default: state <= S_PRE;
                endcase
            end
        end
    end

endmodule
